// File: rtl/lcd_pkg.sv
// Shared window geometry and read-side FSM encoding for the LCD display path.
package lcd_pkg;

  localparam int WIN_W      = 3;
  localparam int WIN_H      = 3;
  localparam int WIN_PIXELS = WIN_W * WIN_H;
  localparam int DATA_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_t;

  // Row of raster index idx within a WIN_W-wide window.
  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    logic [3:0] q;
    q = idx / 4'(WIN_W);
    return q[1:0];
  endfunction

  // Column of raster index idx within a WIN_W-wide window.
  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    logic [3:0] r;
    r = idx % 4'(WIN_W);
    return r[1:0];
  endfunction

endpackage

// File: rtl/lcd_win_bank.sv
// One window of pixel storage: synchronous write port, combinational read port.
// Contents are deliberately not reset; a bank is only read after a full commit.
module lcd_win_bank #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [3:0]        i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [lcd_pkg::WIN_PIXELS];

  // Store one byte at the write index.
  always_ff @(posedge clk) begin
    if (i_we && (i_wr_idx < 4'(lcd_pkg::WIN_PIXELS))) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Read selected pixel; out-of-window indices return zero.
  always_comb begin
    o_rd_data = '0;
    if (i_rd_idx < 4'(lcd_pkg::WIN_PIXELS)) begin
      o_rd_data = r_mem[i_rd_idx];
    end
  end

endmodule

// File: rtl/lcd_win_sink.sv
// Captures 9-byte window bursts into a ping-pong buffer and replays each
// window as row/column-tagged pixels over a valid/ready handshake.
module lcd_win_sink #(
  parameter int DATA_W = lcd_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] win_data,
  input  logic              win_valid,
  output logic [DATA_W-1:0] px_data,
  output logic [1:0]        px_row,
  output logic [1:0]        px_col,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              short_burst,
  output logic [1:0]        buf_level
);

  import lcd_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(WIN_PIXELS - 1);

  // Write side
  logic       r_wr_ptr;
  logic [3:0] r_wr_idx;
  logic       r_dropping;
  logic       w_drop_start;
  logic       w_we;
  logic       w_wr_last;
  logic       w_commit;
  logic       w_trunc;

  // Read side
  rd_state_t  r_state, w_state_nx;
  logic       r_rd_ptr, w_rd_ptr_nx;
  logic [3:0] r_rd_idx, w_rd_idx_nx;
  logic       w_load;
  logic       w_drain;
  logic       w_valid_nx;
  logic [1:0] r_level, w_level_nx;

  // Registered outputs
  logic              r_px_valid;
  logic [DATA_W-1:0] r_px_data;
  logic [1:0]        r_px_row;
  logic [1:0]        r_px_col;
  logic              r_frame_done;
  logic              r_overflow;
  logic              r_short_burst;

  // Bank ports
  logic              w_we0, w_we1;
  logic [DATA_W-1:0] w_rd0, w_rd1, w_rd_data;

  // Classify the current input cycle: store, drop start, commit or truncation.
  always_comb begin
    w_drop_start = win_valid && !r_dropping && (r_wr_idx == '0) && (r_level == 2'd2);
    w_we         = win_valid && !r_dropping && !w_drop_start;
    w_wr_last    = (r_wr_idx == LAST_IDX);
    w_commit     = w_we && w_wr_last;
    w_trunc      = !win_valid && !r_dropping && (r_wr_idx != '0);
  end

  assign w_we0 = w_we && !r_wr_ptr;
  assign w_we1 = w_we &&  r_wr_ptr;

  lcd_win_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk       (clk),
    .i_we      (w_we0),
    .i_wr_idx  (r_wr_idx),
    .i_wr_data (win_data),
    .i_rd_idx  (w_rd_idx_nx),
    .o_rd_data (w_rd0)
  );

  lcd_win_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk       (clk),
    .i_we      (w_we1),
    .i_wr_idx  (r_wr_idx),
    .i_wr_data (win_data),
    .i_rd_idx  (w_rd_idx_nx),
    .o_rd_data (w_rd1)
  );

  // Write pointer, byte index, drop mode and write-side flag pulses.
  // Dropped bytes still advance the index so drop mode ends after 9 bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= 1'b0;
      r_wr_idx      <= '0;
      r_dropping    <= 1'b0;
      r_overflow    <= 1'b0;
      r_short_burst <= 1'b0;
    end else begin
      r_overflow    <= w_drop_start;
      r_short_burst <= w_trunc;
      if (win_valid) begin
        if (w_wr_last) begin
          r_wr_idx   <= '0;
          r_dropping <= 1'b0;
          if (w_commit) begin
            r_wr_ptr <= ~r_wr_ptr;
          end
        end else begin
          r_wr_idx   <= r_wr_idx + 4'd1;
          r_dropping <= r_dropping | w_drop_start;
        end
      end else begin
        r_wr_idx   <= '0;
        r_dropping <= 1'b0;
      end
    end
  end

  // Read FSM next state; the bank read address is the next pixel index so the
  // output registers load the upcoming pixel on the same edge as the advance.
  always_comb begin
    w_state_nx  = r_state;
    w_rd_ptr_nx = r_rd_ptr;
    w_rd_idx_nx = r_rd_idx;
    w_load      = 1'b0;
    w_drain     = 1'b0;
    w_valid_nx  = r_px_valid;
    unique case (r_state)
      IDLE: begin
        if (r_level != 2'd0) begin
          w_state_nx  = SEND;
          w_rd_idx_nx = '0;
          w_load      = 1'b1;
          w_valid_nx  = 1'b1;
        end
      end
      SEND: begin
        if (r_px_valid && px_ready) begin
          if (r_rd_idx == LAST_IDX) begin
            w_drain     = 1'b1;
            w_rd_ptr_nx = ~r_rd_ptr;
            w_rd_idx_nx = '0;
            if (w_level_nx != 2'd0) begin
              w_load     = 1'b1;
              w_valid_nx = 1'b1;
            end else begin
              w_state_nx = IDLE;
              w_valid_nx = 1'b0;
            end
          end else begin
            w_rd_idx_nx = r_rd_idx + 4'd1;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Level after this edge's commit and drain; both together cancel out.
  always_comb begin
    w_level_nx = r_level;
    unique case ({w_commit, w_drain})
      2'b10:   w_level_nx = r_level + 2'd1;
      2'b01:   w_level_nx = r_level - 2'd1;
      default: w_level_nx = r_level;
    endcase
  end

  assign w_rd_data = w_rd_ptr_nx ? w_rd1 : w_rd0;

  // Read FSM state, pointers, level and registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rd_ptr     <= 1'b0;
      r_rd_idx     <= '0;
      r_level      <= '0;
      r_px_valid   <= 1'b0;
      r_px_data    <= '0;
      r_px_row     <= '0;
      r_px_col     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_rd_ptr     <= w_rd_ptr_nx;
      r_rd_idx     <= w_rd_idx_nx;
      r_level      <= w_level_nx;
      r_px_valid   <= w_valid_nx;
      r_frame_done <= w_drain;
      if (w_load) begin
        r_px_data <= w_rd_data;
        r_px_row  <= idx_row(w_rd_idx_nx);
        r_px_col  <= idx_col(w_rd_idx_nx);
      end
    end
  end

  assign px_data     = r_px_data;
  assign px_row      = r_px_row;
  assign px_col      = r_px_col;
  assign px_valid    = r_px_valid;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign short_burst = r_short_burst;
  assign buf_level   = r_level;

endmodule
